vram_plane_ctrl: RTL and testbench
==================================

VRAM_PLANE_CTRL -- requirements
Module: vram_plane_ctrl

Interface
REQ-001 SHALL have parameter NUM_PLANES, default 6, number of bit-plane memories (1..8).
REQ-002 SHALL have parameter ADDR_W, default 13, plane address width.
REQ-003 SHALL have parameters RD_PORT, WR_PORT and CLR_PORT, defaults 8'hF1, 8'hF2 and 8'hF0, the IO port numbers.
REQ-004 SHALL have port clk  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port io_wr  in  1  one-cycle IO write strobe.
REQ-007 SHALL have ports io_port  in  8  IO port number, and io_data  in  8  IO write data.
REQ-008 SHALL have ports mem_rd  in  1  and mem_wr  in  1  CPU VRAM access strobes.
REQ-009 SHALL have ports cpu_addr  in  ADDR_W, cpu_din  in  8, and cpu_dout  out  8  read data.
REQ-010 SHALL have port cpu_wait_n  out  1  low = CPU access stalled.
REQ-011 SHALL have ports clear_req  in  1  hardware clear pulse, and busy  out  1  clear in progress.
REQ-012 SHALL have ports pl_addr  out  ADDR_W, pl_din  out  8, pl_we  out  1, pl_ce  out  NUM_PLANES  (active-high, one per plane).
REQ-013 SHALL have port pl_q  in  8*NUM_PLANES  plane read data, plane k at bits [8k+7:8k]; memories have 1-cycle read latency.
REQ-014 SHALL have ports rd_bank  out  8  and wr_mask  out  NUM_PLANES  current register values.

Function
REQ-015 io_wr with io_port==RD_PORT SHALL load rd_bank <= io_data, visible the following cycle.
REQ-016 io_wr with io_port==WR_PORT SHALL load wr_mask <= io_data[NUM_PLANES-1:0]; upper bits ignored.
REQ-017 io_wr with io_port==CLR_PORT SHALL start a clear, identical to clear_req.
REQ-018 In IDLE, mem_wr SHALL drive pl_addr=cpu_addr, pl_din=cpu_din, pl_we=1, pl_ce=wr_mask in the same cycle (multi-plane broadcast write).
REQ-019 In IDLE, mem_rd (mem_wr low) SHALL drive pl_we=0 and pl_ce = one-hot bit (rd_bank-1) when 1<=rd_bank<=NUM_PLANES, else all zero.
REQ-020 A read at cycle T SHALL latch the plane select; cpu_dout SHALL present that plane's pl_q at T+1 and hold until the next read completes.
REQ-021 Read with rd_bank 0 or >NUM_PLANES SHALL return cpu_dout=8'h00 at T+1.
REQ-022 mem_rd and mem_wr together SHALL perform the write only; cpu_dout unchanged.
REQ-023 FSM states IDLE, CLEAR; IDLE->CLEAR on clear_req or CLR_PORT write; address counter set to 0.
REQ-024 In CLEAR, each cycle SHALL drive pl_addr=counter, pl_din=8'h00, pl_we=1, pl_ce=all ones, then increment counter.
REQ-025 CLEAR->IDLE after the write to address 2^ADDR_W-1 (counter wraps to 0); clear takes exactly 2^ADDR_W cycles.
REQ-026 busy SHALL be 1 for every CLEAR cycle, 0 in IDLE.
REQ-027 In CLEAR, cpu_wait_n SHALL be 0 while mem_rd or mem_wr is asserted; no CPU plane access occurs; access executes in the first IDLE cycle if still asserted.
REQ-028 cpu_wait_n SHALL be 1 in IDLE.
REQ-029 clear_req/CLR_PORT write during CLEAR SHALL restart the counter at 0.
REQ-030 IO register writes SHALL be accepted in both states; io_wr and clear_req in the same cycle both take effect.

Reset
REQ-031 reset_n low SHALL asynchronously force: state IDLE, counter 0, rd_bank 8'h00, wr_mask 0, cpu_dout 8'h00, busy 0, cpu_wait_n 1.
REQ-032 Reset mid-clear SHALL abort the clear; no further plane writes until a new request.
REQ-033 While reset_n low, pl_ce=0 and pl_we=0.

Structure
REQ-034 Shared package SHALL hold the FSM state enum and default port constants (F0/F1/F2).
REQ-035 Plane memories SHALL remain external; no sub-module required; optional sub-module plane_rd_mux for the read select.

Verification
REQ-036 wr_mask=6'b000101, write 8'hA5 @ 0x0123 -> planes 0 and 2 ce, pl_din 8'hA5; planes 1,3,4,5 untouched.
REQ-037 rd_bank=3, read 0x0123 with plane 2 holding 8'h3C -> pl_ce=6'b000100 at T, cpu_dout 8'h3C at T+1.
REQ-038 rd_bank=0 and rd_bank=7, read -> pl_ce=0, cpu_dout 8'h00.
REQ-039 clear_req pulse, mem_wr held at cycle 10 -> busy high 8192 cycles, all-plane zero writes 0..0x1FFF, cpu_wait_n low until IDLE, write then executes.
REQ-040 reset_n low at clear cycle 100 -> busy 0 immediately, no plane writes after release.
REQ-041 clear_req repeated at clear cycle 50 -> counter restarts at 0, busy lasts 50+8192 cycles total.

Source files
------------

// File: rtl/vram_plane_ctrl_pkg.sv
// Shared types and default IO port numbers for the VRAM bit-plane controller.
package vram_plane_ctrl_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam logic [7:0] DEF_CLR_PORT = 8'hF0;
   localparam logic [7:0] DEF_RD_PORT  = 8'hF1;
   localparam logic [7:0] DEF_WR_PORT  = 8'hF2;

endpackage

// File: rtl/vram_plane_ctrl_rd_mux.sv
// One-hot AND-OR selector picking one plane's read data; an all-zero select yields 8'h00.
module plane_rd_mux #(
   parameter int NUM_PLANES = 6
) (
   input  logic [NUM_PLANES-1:0]   sel,
   input  logic [8*NUM_PLANES-1:0] pl_q,
   output logic [7:0]              dout
);

   logic [NUM_PLANES:0][7:0] acc;

   assign acc[0] = 8'h00;

   for (genvar k = 0; k < NUM_PLANES; k++) begin : g_plane
      assign acc[k+1] = acc[k] | (pl_q[8*k +: 8] & {8{sel[k]}});
   end

   assign dout = acc[NUM_PLANES];

endmodule

// File: rtl/vram_plane_ctrl.sv
// VRAM bit-plane controller: CPU broadcast writes, banked reads, and a hardware
// clear sequencer that zeroes every plane while stalling the CPU.
module vram_plane_ctrl
   import vram_plane_ctrl_pkg::*;
#(
   parameter int         NUM_PLANES = 6,
   parameter int         ADDR_W     = 13,
   parameter logic [7:0] RD_PORT    = DEF_RD_PORT,
   parameter logic [7:0] WR_PORT    = DEF_WR_PORT,
   parameter logic [7:0] CLR_PORT   = DEF_CLR_PORT
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    io_wr,
   input  logic [7:0]              io_port,
   input  logic [7:0]              io_data,
   input  logic                    mem_rd,
   input  logic                    mem_wr,
   input  logic [ADDR_W-1:0]       cpu_addr,
   input  logic [7:0]              cpu_din,
   output logic [7:0]              cpu_dout,
   output logic                    cpu_wait_n,
   input  logic                    clear_req,
   output logic                    busy,
   output logic [ADDR_W-1:0]       pl_addr,
   output logic [7:0]              pl_din,
   output logic                    pl_we,
   output logic [NUM_PLANES-1:0]   pl_ce,
   input  logic [8*NUM_PLANES-1:0] pl_q,
   output logic [7:0]              rd_bank,
   output logic [NUM_PLANES-1:0]   wr_mask
);

   state_t                  state;
   logic [ADDR_W-1:0]       clr_cnt;
   logic                    clr_start;
   logic                    rd_go;
   logic [NUM_PLANES-1:0]   rd_ce;
   logic                    rd_pend_q;
   logic [NUM_PLANES-1:0]   rd_sel_q;
   logic [7:0]              dout_hold_q;
   logic [7:0]              mux_dout;

   assign clr_start = clear_req | (io_wr && io_port == CLR_PORT);
   assign rd_go     = (state == ST_IDLE) && mem_rd && !mem_wr;

   // Bank numbers are 1-based; 0 and anything past the last plane select nothing.
   always_comb begin
      rd_ce = '0;
      for (int k = 0; k < NUM_PLANES; k++)
         rd_ce[k] = (rd_bank == 8'(k + 1));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_bank <= 8'h00;
         wr_mask <= '0;
      end else if (io_wr) begin
         if (io_port == RD_PORT) rd_bank <= io_data;
         if (io_port == WR_PORT) wr_mask <= io_data[NUM_PLANES-1:0];
      end
   end

   // A new request restarts the sweep from address 0 even mid-clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= ST_IDLE;
         clr_cnt <= '0;
         busy    <= 1'b0;
      end else if (clr_start) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
         busy    <= 1'b1;
      end else if (state == ST_CLEAR) begin
         clr_cnt <= clr_cnt + 1'b1;
         if (clr_cnt == '1) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
         end
      end
   end

   always_comb begin
      pl_addr = cpu_addr;
      pl_din  = cpu_din;
      pl_we   = 1'b0;
      pl_ce   = '0;
      if (!reset_n) begin
         pl_we = 1'b0;
      end else if (state == ST_CLEAR) begin
         pl_addr = clr_cnt;
         pl_din  = 8'h00;
         pl_we   = 1'b1;
         pl_ce   = '1;
      end else if (mem_wr) begin
         pl_we = 1'b1;
         pl_ce = wr_mask;
      end else if (mem_rd) begin
         pl_ce = rd_ce;
      end
   end

   assign cpu_wait_n = !((state == ST_CLEAR) && (mem_rd || mem_wr));

   // Read data appears the cycle after the access and is held afterwards.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend_q   <= 1'b0;
         rd_sel_q    <= '0;
         dout_hold_q <= 8'h00;
      end else begin
         rd_pend_q <= rd_go;
         if (rd_go)     rd_sel_q    <= rd_ce;
         if (rd_pend_q) dout_hold_q <= mux_dout;
      end
   end

   plane_rd_mux #(.NUM_PLANES(NUM_PLANES)) u_rd_mux (
      .sel  (rd_sel_q),
      .pl_q (pl_q),
      .dout (mux_dout)
   );

   assign cpu_dout = rd_pend_q ? mux_dout : dout_hold_q;

endmodule

// File: tb/tb_vram_plane_ctrl.sv
// Bench for vram_plane_ctrl: behavioural plane memories, read scoreboard, clear sequencing.
module tb_vram_plane_ctrl;

   localparam int         NP       = 6;
   localparam int         AW       = 13;
   localparam int         DEPTH    = 1 << AW;
   localparam logic [7:0] CLR_PORT = 8'hF0;
   localparam logic [7:0] RD_PORT  = 8'hF1;
   localparam logic [7:0] WR_PORT  = 8'hF2;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            io_wr;
   logic [7:0]      io_port, io_data;
   logic            mem_rd, mem_wr;
   logic [AW-1:0]   cpu_addr;
   logic [7:0]      cpu_din, cpu_dout;
   logic            cpu_wait_n, clear_req, busy;
   logic [AW-1:0]   pl_addr;
   logic [7:0]      pl_din;
   logic            pl_we;
   logic [NP-1:0]   pl_ce;
   logic [8*NP-1:0] pl_q;
   logic [7:0]      rd_bank;
   logic [NP-1:0]   wr_mask;

   int n_chk = 0;
   int n_err = 0;
   int wr_cnt = 0;
   logic [7:0] sb_q[$];
   logic       rd_now = 1'b0;
   logic       rd_due = 1'b0;
   logic [7:0] mem     [NP][DEPTH];
   logic [7:0] exp_mem [NP][DEPTH];

   always #5 clk = ~clk;

   vram_plane_ctrl #(.NUM_PLANES(NP), .ADDR_W(AW)) dut (
      .clk(clk), .reset_n(reset_n), .io_wr(io_wr), .io_port(io_port), .io_data(io_data),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_dout(cpu_dout), .cpu_wait_n(cpu_wait_n), .clear_req(clear_req), .busy(busy),
      .pl_addr(pl_addr), .pl_din(pl_din), .pl_we(pl_we), .pl_ce(pl_ce), .pl_q(pl_q),
      .rd_bank(rd_bank), .wr_mask(wr_mask)
   );

   function automatic logic [7:0] pat(input int k, input int a);
      return 8'((k + 1) * 16 + (a % 16));
   endfunction

   // External plane memories with one-cycle read latency.
   initial begin
      pl_q = '0;
      for (int k = 0; k < NP; k++)
         for (int a = 0; a < DEPTH; a++)
            mem[k][a] = pat(k, a);
      forever begin
         @(posedge clk);
         if (pl_we && (pl_ce != '0)) wr_cnt <= wr_cnt + 1;
         for (int k = 0; k < NP; k++)
            if (pl_ce[k]) begin
               if (pl_we) mem[k][pl_addr] <= pl_din;
               else       pl_q[8*k +: 8] <= mem[k][pl_addr];
            end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   always @(posedge clk) rd_due <= rd_now;

   always @(negedge clk) begin
      if (rd_due) begin
         chk("sb_avail", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) chk("rd_data", cpu_dout, sb_q.pop_front());
      end
   end

   task automatic io_write(input logic [7:0] p, input logic [7:0] d);
      @(negedge clk);
      io_wr = 1'b1; io_port = p; io_data = d;
      @(negedge clk);
      io_wr = 1'b0;
      #1;
   endtask

   task automatic cpu_write(input logic [AW-1:0] a, input logic [7:0] d, input logic [NP-1:0] m);
      @(negedge clk);
      mem_wr = 1'b1; cpu_addr = a; cpu_din = d;
      #1;
      chk("wr_ce", pl_ce, m);
      chk("wr_we", pl_we, 1);
      chk("wr_din", pl_din, d);
      chk("wr_addr", pl_addr, a);
      for (int k = 0; k < NP; k++) if (m[k]) exp_mem[k][a] = d;
      @(negedge clk);
      mem_wr = 1'b0;
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [NP-1:0] ce, input logic [7:0] d);
      @(negedge clk);
      mem_rd = 1'b1; cpu_addr = a;
      #1;
      chk("rd_ce", pl_ce, ce);
      chk("rd_we", pl_we, 0);
      sb_q.push_back(d);
      rd_now = 1'b1;
      @(negedge clk);
      mem_rd = 1'b0; rd_now = 1'b0;
      @(negedge clk);
      #1;
      chk("rd_hold", cpu_dout, d);
   endtask

   // Pulses clear_req, then follows the sweep cycle by cycle until busy drops.
   task automatic run_clear(input int restart_at, input int wr_at, output int n);
      int exp_cnt;
      int bad;
      exp_cnt = 0; bad = 0; n = 0;
      @(negedge clk); clear_req = 1'b1;
      @(negedge clk); clear_req = 1'b0;
      for (int c = 0; c < 20000; c++) begin
         #1;
         if (!busy) break;
         if (pl_addr !== exp_cnt[AW-1:0] || pl_we !== 1'b1 || pl_ce !== '1 || pl_din !== 8'h00) bad++;
         if ((mem_wr || mem_rd) && cpu_wait_n !== 1'b0) bad++;
         if (n == wr_at) mem_wr = 1'b1;
         clear_req = (n + 1 == restart_at);
         io_wr     = (n + 1 == restart_at);
         exp_cnt   = (n + 1 == restart_at) ? 0 : exp_cnt + 1;
         n++;
         @(negedge clk);
      end
      chk("clr_seq", bad, 0);
   endtask

   initial begin
      int n, w0;
      logic [NP-1:0] oh;
      for (int k = 0; k < NP; k++)
         for (int a = 0; a < DEPTH; a++)
            exp_mem[k][a] = pat(k, a);
      reset_n = 1'b0; io_wr = 1'b0; io_port = 8'h00; io_data = 8'h00;
      mem_rd = 1'b0; mem_wr = 1'b1; cpu_addr = 13'h0010; cpu_din = 8'hFF; clear_req = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_pl_we", pl_we, 0);
      chk("rst_pl_ce", pl_ce, 0);
      chk("rst_rd_bank", rd_bank, 0);
      chk("rst_wr_mask", wr_mask, 0);
      chk("rst_dout", cpu_dout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wait_n", cpu_wait_n, 1);
      mem_wr = 1'b0;
      @(negedge clk); reset_n = 1'b1;

      io_write(WR_PORT, 8'hC5);
      chk("wr_mask_load", wr_mask, 6'b000101);
      cpu_write(13'h0123, 8'hA5, 6'b000101);
      io_write(WR_PORT, 8'h04);
      cpu_write(13'h0123, 8'h3C, 6'b000100);

      io_write(RD_PORT, 8'd3);
      chk("rd_bank_load", rd_bank, 8'd3);
      do_read(13'h0123, 6'b000100, 8'h3C);
      for (int b = 1; b <= NP; b++) begin
         io_write(RD_PORT, 8'(b));
         oh = '0; oh[b-1] = 1'b1;
         do_read(13'h0123, oh, exp_mem[b-1][13'h0123]);
      end
      io_write(RD_PORT, 8'd0);
      do_read(13'h0123, '0, 8'h00);
      io_write(RD_PORT, 8'd7);
      do_read(13'h0123, '0, 8'h00);

      io_write(RD_PORT, 8'd1);
      do_read(13'h0123, 6'b000001, 8'hA5);
      io_write(WR_PORT, 8'h02);
      @(negedge clk);
      mem_rd = 1'b1; mem_wr = 1'b1; cpu_addr = 13'h0200; cpu_din = 8'h77;
      #1;
      chk("rdwr_we", pl_we, 1);
      chk("rdwr_ce", pl_ce, 6'b000010);
      exp_mem[1][13'h0200] = 8'h77;
      @(negedge clk);
      mem_rd = 1'b0; mem_wr = 1'b0;
      #1;
      chk("rdwr_dout", cpu_dout, 8'hA5);

      cpu_addr = 13'h0055; cpu_din = 8'h99;
      run_clear(-1, 10, n);
      chk("clr_len", n, DEPTH);
      chk("clr_wait_release", cpu_wait_n, 1);
      chk("clr_held_we", pl_we, 1);
      chk("clr_held_ce", pl_ce, 6'b000010);
      chk("clr_held_addr", pl_addr, 13'h0055);
      chk("clr_held_din", pl_din, 8'h99);
      for (int k = 0; k < NP; k++)
         for (int a = 0; a < DEPTH; a++)
            exp_mem[k][a] = 8'h00;
      exp_mem[1][13'h0055] = 8'h99;
      @(negedge clk); mem_wr = 1'b0;
      io_write(RD_PORT, 8'd2);
      do_read(13'h0055, 6'b000010, exp_mem[1][13'h0055]);
      io_write(RD_PORT, 8'd1);
      do_read(13'h0123, 6'b000001, exp_mem[0][13'h0123]);

      io_port = RD_PORT; io_data = 8'd5;
      run_clear(50, -1, n);
      chk("restart_len", n, 50 + DEPTH);
      chk("restart_io", rd_bank, 8'd5);

      io_write(CLR_PORT, 8'h00);
      repeat (100) @(negedge clk);
      chk("abort_busy_pre", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_we", pl_we, 0);
      chk("abort_ce", pl_ce, 0);
      chk("abort_rd_bank", rd_bank, 0);
      @(negedge clk); reset_n = 1'b1;
      w0 = wr_cnt;
      repeat (30) @(negedge clk);
      chk("abort_no_wr", wr_cnt - w0, 0);
      chk("abort_idle", busy, 0);

      chk("sb_empty", sb_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
